vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA timing from the 100 MHz board clock. Produces the `hCount`/`vCount`/`bright` scan coordinates consumed by the rendering controller and the `hSync`/`vSync` pins driven to the connector. Also produces frame-rate strobes and a free-running frame counter for sprite animation and game-tick logic. All outputs are registered and mutually aligned, so downstream combinational pixel muxes see a consistent coordinate.

## Interface

**Parameters**
- `CLK_DIV`, default 4: clk cycles per pixel (100 MHz / 4 = 25 MHz); legal values 2..16.
- `H_SYNC` / `H_BACK` / `H_VIS` / `H_FRONT`, defaults 96 / 48 / 640 / 16: horizontal segment lengths in pixels; total `H_TOTAL` = 800.
- `V_SYNC` / `V_BACK` / `V_VIS` / `V_FRONT`, defaults 2 / 33 / 480 / 10: vertical segment lengths in lines; total `V_TOTAL` = 525.

**Ports**
- `clk`, input, 1: board clock, 100 MHz.
- `reset`, input, 1: asynchronous, active-high.
- `pix_tick`, output, 1: one-clk pulse each pixel period; counters advance on it.
- `hCount`, output, 10: horizontal position, 0..H_TOTAL-1, origin at hsync start.
- `vCount`, output, 10: vertical line, 0..V_TOTAL-1, origin at vsync start.
- `bright`, output, 1: high inside the visible window.
- `hSync`, output, 1: active-low horizontal sync.
- `vSync`, output, 1: active-low vertical sync.
- `line_end`, output, 1: one-clk pulse on the tick where `hCount` wraps to 0.
- `frame_start`, output, 1: one-clk pulse on the tick where both counters wrap to 0.
- `frame_count`, output, 8: frames completed since reset, wraps 255 -> 0.

## Operation

- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_tick` is registered high for the single clk cycle in which `div_cnt` == CLK_DIV-1.
- Horizontal counter: on each `pix_tick`, `hCount` increments. At H_TOTAL-1 it wraps to 0 and `vCount` advances.
- Vertical counter: `vCount` increments on each horizontal wrap. At V_TOTAL-1 it wraps to 0 and `frame_count` increments.
- Sync decode is computed from the next-count values and registered with the counters, so outputs always match the displayed coordinate:
  - `hSync` = 0 iff `hCount` < H_SYNC (0..95).
  - `vSync` = 0 iff `vCount` < V_SYNC (0..1).
  - `bright` = 1 iff H_SYNC+H_BACK ≤ `hCount` < H_SYNC+H_BACK+H_VIS (144..783) **and** V_SYNC+V_BACK ≤ `vCount` < V_SYNC+V_BACK+V_VIS (35..514).
- Strobes:
  - `line_end` is high in the same clk cycle that `hCount` first reads 0 after a wrap.
  - `frame_start` is high in the same clk cycle that (`hCount`,`vCount`) first reads (0,0) after a wrap. It is not asserted after reset release.
- Width rules: all comparisons unsigned, 10-bit. Parameter totals must be ≤ 1024.

## Timing

- Reset values (asynchronous, immediate):
  - `div_cnt` = 0, `hCount` = 0, `vCount` = 0.
  - `hSync` = 0, `vSync` = 0, `bright` = 0.
  - `pix_tick` = 0, `line_end` = 0, `frame_start` = 0, `frame_count` = 0.
- After reset deasserts, the first `pix_tick` occurs on clk edge CLK_DIV. Counters then hold each value for exactly CLK_DIV clk cycles.
- Counters and all decodes update on the same clk edge, 1 cycle after the edge on which `pix_tick` is registered. Zero skew between `hCount`/`vCount`/`bright`/syncs.
- Line period = H_TOTAL × CLK_DIV = 3200 clk. Frame period = 525 × 3200 = 1 680 000 clk.
- Simultaneous horizontal and vertical wrap: `line_end` and `frame_start` assert in the same cycle.
- Reset asserted mid-frame: all state returns to reset values immediately. The sequence restarts as after power-up, with no `frame_start` pulse.

## Test plan

- **Reset release:** hold `reset` 5 cycles, release.
  - Expect `hCount`=0, `vCount`=0, `hSync`=0, `bright`=0.
  - First `pix_tick` after 4 clk; `hCount`=1 on the following edge.
- **Horizontal timing:** run one line.
  - `hSync` low for exactly 96×4 = 384 clk.
  - On a visible line (`vCount`=35), `bright` rises at `hCount`=144 and falls at `hCount`=784.
  - `line_end` pulses once per 3200 clk.
- **Vertical timing:** run 2 frames.
  - `vSync` low for 2 lines (6400 clk).
  - `bright` never high for `vCount` ≤ 34 or ≥ 515.
  - `frame_start` spacing is exactly 1 680 000 clk, coincident with `line_end`.
- **Frame counter wrap:** run 256 frames (or force `frame_count`=255 near the wrap).
  - Expect 255 -> 0 on `frame_start`, with no glitch on other outputs.
- **Mid-operation reset:** assert `reset` at `hCount`=500, `vCount`=300, asynchronously between clk edges.
  - All outputs go to reset values before the next edge.
  - After release, the sequence matches the reset-release scenario.
- **Parameter override:** `CLK_DIV`=2.
  - `pix_tick` every 2 clk; line period 1600 clk; decode positions unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA scan generator: pixel-rate divider, h/v counters, registered
// sync/visible decode, line/frame strobes and a free-running frame counter.
`timescale 1ns/100ps
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VIS   = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VIS   = 480,
  parameter int V_FRONT = 10
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       line_end,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_VIS + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_VIS + V_FRONT;
  localparam int H_VIS_START = H_SYNC + H_BACK;
  localparam int H_VIS_END   = H_VIS_START + H_VIS;
  localparam int V_VIS_START = V_SYNC + V_BACK;
  localparam int V_VIS_END   = V_VIS_START + V_VIS;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

  logic [3:0] div_cnt_reg;
  logic       pix_tick_reg;
  logic [9:0] h_count_reg, h_count_next;
  logic [9:0] v_count_reg, v_count_next;
  logic [7:0] frame_count_reg, frame_count_next;
  logic       h_sync_reg, h_sync_next;
  logic       v_sync_reg, v_sync_next;
  logic       bright_reg, bright_next;
  logic       line_end_reg, line_end_next;
  logic       frame_start_reg, frame_start_next;
  logic       h_wrap, v_wrap;
  logic [10:0] h_ext, v_ext;

  always_comb begin
    h_wrap           = (h_count_reg == H_LAST);
    v_wrap           = (v_count_reg == V_LAST);
    h_count_next     = h_count_reg;
    v_count_next     = v_count_reg;
    frame_count_next = frame_count_reg;
    if (pix_tick_reg) begin
      if (h_wrap) begin
        h_count_next = 10'd0;
        if (v_wrap) begin
          v_count_next     = 10'd0;
          frame_count_next = frame_count_reg + 8'd1;
        end else begin
          v_count_next = v_count_reg + 10'd1;
        end
      end else begin
        h_count_next = h_count_reg + 10'd1;
      end
    end
  end

  // Decode from the next counts so syncs/bright land on the same edge as the counters.
  // 11-bit compares keep a window end of exactly 1024 representable.
  always_comb begin
    h_ext            = {1'b0, h_count_next};
    v_ext            = {1'b0, v_count_next};
    h_sync_next      = (h_ext >= 11'(H_SYNC));
    v_sync_next      = (v_ext >= 11'(V_SYNC));
    bright_next      = (h_ext >= 11'(H_VIS_START)) && (h_ext < 11'(H_VIS_END)) &&
                       (v_ext >= 11'(V_VIS_START)) && (v_ext < 11'(V_VIS_END));
    line_end_next    = pix_tick_reg && h_wrap;
    frame_start_next = pix_tick_reg && h_wrap && v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg     <= 4'd0;
      pix_tick_reg    <= 1'b0;
      h_count_reg     <= 10'd0;
      v_count_reg     <= 10'd0;
      frame_count_reg <= 8'd0;
      h_sync_reg      <= 1'b0;
      v_sync_reg      <= 1'b0;
      bright_reg      <= 1'b0;
      line_end_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_cnt_reg     <= (div_cnt_reg == DIV_LAST) ? 4'd0 : div_cnt_reg + 4'd1;
      pix_tick_reg    <= (div_cnt_reg == DIV_LAST);
      h_count_reg     <= h_count_next;
      v_count_reg     <= v_count_next;
      frame_count_reg <= frame_count_next;
      h_sync_reg      <= h_sync_next;
      v_sync_reg      <= v_sync_next;
      bright_reg      <= bright_next;
      line_end_reg    <= line_end_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign pix_tick    = pix_tick_reg;
  assign hCount      = h_count_reg;
  assign vCount      = v_count_reg;
  assign bright      = bright_reg;
  assign hSync       = h_sync_reg;
  assign vSync       = v_sync_reg;
  assign line_end    = line_end_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, reduced-frame, CLK_DIV=2)
// checked cycle by cycle against a closed-form model of elapsed clocks since reset.
`timescale 1ns/100ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix;
    logic [9:0] h;
    logic [9:0] v;
    logic       bright;
    logic       hs;
    logic       vs;
    logic       le;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  // Reduced-frame instance so 256 frames fit in a short run
  localparam int B_CD = 2, B_HS = 2, B_HB = 1, B_HV = 3, B_HF = 1;
  localparam int B_VS = 1, B_VB = 1, B_VV = 2, B_VF = 1;
  localparam int B_FRAME_CLK = (B_HS + B_HB + B_HV + B_HF) * (B_VS + B_VB + B_VV + B_VF) * B_CD;
  // CLK_DIV=2 instance with default horizontal timing and a short vertical
  localparam int C_VS = 2, C_VB = 1, C_VV = 2, C_VF = 1;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  int   vectors = 0, miscompares = 0;
  int   k_a, k_b, k_c;

  logic       a_pix, a_bright, a_hs, a_vs, a_le, a_fs;
  logic [9:0] a_h, a_v;
  logic [7:0] a_fc;
  logic       b_pix, b_bright, b_hs, b_vs, b_le, b_fs;
  logic [9:0] b_h, b_v;
  logic [7:0] b_fc;
  logic       c_pix, c_bright, c_hs, c_vs, c_le, c_fs;
  logic [9:0] c_h, c_v;
  logic [7:0] c_fc;
  obs_t a_obs, b_obs, c_obs;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .pix_tick(a_pix), .hCount(a_h), .vCount(a_v),
    .bright(a_bright), .hSync(a_hs), .vSync(a_vs), .line_end(a_le),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(B_CD), .H_SYNC(B_HS), .H_BACK(B_HB), .H_VIS(B_HV), .H_FRONT(B_HF),
    .V_SYNC(B_VS), .V_BACK(B_VB), .V_VIS(B_VV), .V_FRONT(B_VF)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_tick(b_pix), .hCount(b_h), .vCount(b_v),
    .bright(b_bright), .hSync(b_hs), .vSync(b_vs), .line_end(b_le),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .V_SYNC(C_VS), .V_BACK(C_VB), .V_VIS(C_VV), .V_FRONT(C_VF)
  ) dut_c (
    .clk(clk), .reset(rst_c), .pix_tick(c_pix), .hCount(c_h), .vCount(c_v),
    .bright(c_bright), .hSync(c_hs), .vSync(c_vs), .line_end(c_le),
    .frame_start(c_fs), .frame_count(c_fc)
  );

  assign a_obs = {a_pix, a_h, a_v, a_bright, a_hs, a_vs, a_le, a_fs, a_fc};
  assign b_obs = {b_pix, b_h, b_v, b_bright, b_hs, b_vs, b_le, b_fs, b_fc};
  assign c_obs = {c_pix, c_h, c_v, c_bright, c_hs, c_vs, c_le, c_fs, c_fc};

  // Clock edges since reset release, one counter per instance
  always @(posedge clk or posedge rst_a) if (rst_a) k_a <= 0; else k_a <= k_a + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) k_b <= 0; else k_b <= k_b + 1;
  always @(posedge clk or posedge rst_c) if (rst_c) k_c <= 0; else k_c <= k_c + 1;

  // Expected outputs after k clock edges: pixels elapsed = (k-1)/cd, split by division
  function automatic obs_t model(input int k, input int cd,
                                 input int hs, input int hb, input int hv, input int hf,
                                 input int vs, input int vb, input int vv, input int vf);
    obs_t o;
    int   ht, vt, adv, h, line, v;
    logic moved;
    ht    = hs + hb + hv + hf;
    vt    = vs + vb + vv + vf;
    adv   = (k < 1) ? 0 : (k - 1) / cd;
    h     = adv % ht;
    line  = adv / ht;
    v     = line % vt;
    moved = (k > cd) && (((k - 1) % cd) == 0);
    o.pix    = (k >= cd) && ((k % cd) == 0);
    o.h      = 10'(h);
    o.v      = 10'(v);
    o.bright = (h >= hs + hb) && (h < hs + hb + hv) && (v >= vs + vb) && (v < vs + vb + vv);
    o.hs     = (h >= hs);
    o.vs     = (v >= vs);
    o.le     = moved && (h == 0);
    o.fs     = moved && (h == 0) && (v == 0);
    o.fc     = 8'((line / vt) % 256);
    return o;
  endfunction

  function automatic obs_t model_a(input int k);
    return model(k, 4, 96, 48, 640, 16, 2, 33, 480, 10);
  endfunction
  function automatic obs_t model_b(input int k);
    return model(k, B_CD, B_HS, B_HB, B_HV, B_HF, B_VS, B_VB, B_VV, B_VF);
  endfunction
  function automatic obs_t model_c(input int k);
    return model(k, 2, 96, 48, 640, 16, C_VS, C_VB, C_VV, C_VF);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("tick=%0b h=%0d v=%0d br=%0b hs=%0b vs=%0b le=%0b fs=%0b fc=%0d",
                     o.pix, o.h, o.v, o.bright, o.hs, o.vs, o.le, o.fs, o.fc);
  endfunction

  task automatic test_reset();
    obs_t exp;
    int   first_tick;
    rst_a = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (a_obs !== '0) begin
        miscompares++;
        $display("FAIL reset_hold got %s required all zero", fmt(a_obs));
      end
    end
    rst_a = 1'b0;
    first_tick = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp = model_a(k_a);
      vectors++;
      if (a_obs !== exp) begin
        miscompares++;
        $display("FAIL reset_release k=%0d got %s required %s", k_a, fmt(a_obs), fmt(exp));
      end
      if (a_pix === 1'b1 && first_tick < 0) first_tick = k_a;
      if (k_a == 5) begin
        vectors++;
        if (a_h !== 10'd1) begin
          miscompares++;
          $display("FAIL first_hcount_step got h=%0d required 1", a_h);
        end
      end
    end
    vectors++;
    if (first_tick != 4) begin
      miscompares++;
      $display("FAIL first_pix_tick got edge %0d required 4", first_tick);
    end
  endtask

  task automatic test_horizontal();
    obs_t exp;
    int   hs_low, le_count, le_prev;
    hs_low = 0; le_count = 0; le_prev = -1;
    for (int i = 0; i < 6500 && k_a < 6410; i++) begin
      @(negedge clk);
      exp = model_a(k_a);
      vectors++;
      if (a_obs !== exp) begin
        miscompares++;
        $display("FAIL horizontal k=%0d got %s required %s", k_a, fmt(a_obs), fmt(exp));
      end
      if (k_a >= 3201 && k_a <= 6400 && a_hs === 1'b0) hs_low++;
      if (a_le === 1'b1) begin
        le_count++;
        if (le_prev >= 0) begin
          vectors++;
          if (k_a - le_prev != 3200) begin
            miscompares++;
            $display("FAIL line_period got %0d clk required 3200", k_a - le_prev);
          end
        end
        le_prev = k_a;
      end
    end
    vectors++;
    if (hs_low != 384) begin
      miscompares++;
      $display("FAIL hsync_width got %0d clk required 384", hs_low);
    end
    vectors++;
    if (le_count != 2) begin
      miscompares++;
      $display("FAIL line_end_count got %0d required 2", le_count);
    end
  endtask

  task automatic test_mid_reset();
    obs_t exp;
    int   hold;
    for (int i = 0; i < 4000 && a_h !== 10'd500; i++) begin
      @(negedge clk);
      exp = model_a(k_a);
      vectors++;
      if (a_obs !== exp) begin
        miscompares++;
        $display("FAIL mid_reset_run k=%0d got %s required %s", k_a, fmt(a_obs), fmt(exp));
      end
    end
    vectors++;
    if (a_h !== 10'd500) begin
      miscompares++;
      $display("FAIL wait_h500 timeout got h=%0d required 500", a_h);
    end
    #($urandom_range(4, 1));
    rst_a = 1'b1;
    #0.2;
    vectors++;
    if (a_obs !== '0) begin
      miscompares++;
      $display("FAIL async_reset got %s required all zero", fmt(a_obs));
    end
    hold = $urandom_range(6, 2);
    repeat (hold) begin
      @(negedge clk);
      vectors++;
      if (a_obs !== '0) begin
        miscompares++;
        $display("FAIL async_reset_hold got %s required all zero", fmt(a_obs));
      end
    end
    rst_a = 1'b0;
    repeat (40) begin
      @(negedge clk);
      exp = model_a(k_a);
      vectors++;
      if (a_obs !== exp) begin
        miscompares++;
        $display("FAIL restart k=%0d got %s required %s", k_a, fmt(a_obs), fmt(exp));
      end
    end
  endtask

  task automatic test_param_override();
    obs_t exp;
    logic prev_bright;
    int   pix_prev, le_prev, vs_low, fs_count;
    repeat ($urandom_range(7, 2)) @(negedge clk);
    rst_c = 1'b0;
    prev_bright = 1'b0; pix_prev = -1; le_prev = -1; vs_low = 0; fs_count = 0;
    for (int i = 0; i < 9700 && k_c < 9620; i++) begin
      @(negedge clk);
      exp = model_c(k_c);
      vectors++;
      if (c_obs !== exp) begin
        miscompares++;
        $display("FAIL div2 k=%0d got %s required %s", k_c, fmt(c_obs), fmt(exp));
      end
      if (c_pix === 1'b1) begin
        if (pix_prev >= 0) begin
          vectors++;
          if (k_c - pix_prev != 2) begin
            miscompares++;
            $display("FAIL div2_tick_spacing got %0d required 2", k_c - pix_prev);
          end
        end
        pix_prev = k_c;
      end
      if (c_le === 1'b1) begin
        if (le_prev >= 0) begin
          vectors++;
          if (k_c - le_prev != 1600) begin
            miscompares++;
            $display("FAIL div2_line_period got %0d required 1600", k_c - le_prev);
          end
        end
        le_prev = k_c;
      end
      if (c_bright === 1'b1 && prev_bright === 1'b0) begin
        vectors++;
        if (c_h !== 10'd144) begin
          miscompares++;
          $display("FAIL bright_rise got h=%0d required 144", c_h);
        end
      end
      if (c_bright === 1'b0 && prev_bright === 1'b1) begin
        vectors++;
        if (c_h !== 10'd784) begin
          miscompares++;
          $display("FAIL bright_fall got h=%0d required 784", c_h);
        end
      end
      prev_bright = c_bright;
      if (k_c <= 9600 && c_vs === 1'b0) vs_low++;
      if (c_fs === 1'b1) begin
        fs_count++;
        vectors++;
        if (k_c != 9601 || c_le !== 1'b1) begin
          miscompares++;
          $display("FAIL div2_frame_start got k=%0d le=%0b required k=9601 le=1", k_c, c_le);
        end
      end
    end
    vectors++;
    if (vs_low != 3200) begin
      miscompares++;
      $display("FAIL vsync_width got %0d clk required 3200", vs_low);
    end
    vectors++;
    if (fs_count != 1) begin
      miscompares++;
      $display("FAIL div2_frame_count got %0d pulses required 1", fs_count);
    end
  endtask

  task automatic test_frame_wrap();
    obs_t exp;
    int   fs_prev, fs_count, run;
    logic [7:0] prev_fc;
    repeat ($urandom_range(5, 1)) @(negedge clk);
    rst_b = 1'b0;
    run = $urandom_range(200, 50);
    repeat (run) begin
      @(negedge clk);
      exp = model_b(k_b);
      vectors++;
      if (b_obs !== exp) begin
        miscompares++;
        $display("FAIL small_pre k=%0d got %s required %s", k_b, fmt(b_obs), fmt(exp));
      end
    end
    #($urandom_range(4, 1));
    rst_b = 1'b1;
    #0.2;
    vectors++;
    if (b_obs !== '0) begin
      miscompares++;
      $display("FAIL small_async_reset got %s required all zero", fmt(b_obs));
    end
    repeat ($urandom_range(4, 1)) @(negedge clk);
    rst_b = 1'b0;
    fs_prev = -1; fs_count = 0; prev_fc = 8'd0;
    for (int i = 0; i < 256 * B_FRAME_CLK + 20; i++) begin
      @(negedge clk);
      exp = model_b(k_b);
      vectors++;
      if (b_obs !== exp) begin
        miscompares++;
        $display("FAIL small_run k=%0d got %s required %s", k_b, fmt(b_obs), fmt(exp));
      end
      if (b_fs === 1'b1) begin
        fs_count++;
        vectors++;
        if (b_le !== 1'b1) begin
          miscompares++;
          $display("FAIL fs_with_le got le=%0b required 1", b_le);
        end
        if (fs_prev >= 0) begin
          vectors++;
          if (k_b - fs_prev != B_FRAME_CLK) begin
            miscompares++;
            $display("FAIL frame_period got %0d required %0d", k_b - fs_prev, B_FRAME_CLK);
          end
        end
        if (fs_count == 256) begin
          vectors++;
          if (b_fc !== 8'd0 || prev_fc !== 8'd255) begin
            miscompares++;
            $display("FAIL fc_wrap got %0d->%0d required 255->0", prev_fc, b_fc);
          end
        end
        fs_prev = k_b;
      end
      prev_fc = b_fc;
    end
    vectors++;
    if (fs_count != 256) begin
      miscompares++;
      $display("FAIL frame_start_count got %0d required 256", fs_count);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_mid_reset();
    test_param_override();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
